// File: rtl/grid_pkg.sv
// Shared constants and enumerations for the keypad grid cursor controller.
package grid_pkg;

  localparam int unsigned GRID_COLS = 6;
  localparam int unsigned GRID_ROWS = 4;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} move_state_t;

endpackage

// File: rtl/key_repeat_timer.sv
// Hold/auto-repeat timer: after a start pulse, emits step pulses while the
// latched button stays high (first after HOLD_CYCLES, then every REPEAT_CYCLES).
module key_repeat_timer
  import grid_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic level,
  output logic step_c,
  output logic busy_c
);

  localparam int unsigned MAX_CYCLES  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W       = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  move_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and step pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_c  = 1'b0;
    busy_c  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (!level) begin
          state_d = S_IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          step_c  = 1'b1;
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REPEAT: begin
        if (!level) begin
          state_d = S_IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          step_c = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/grid_cursor_ctrl.sv
// Keypad grid cursor: button edge detection, wrapping cursor moves with
// auto-repeat, enter key valid/ready handshake and per-pixel highlight.
module grid_cursor_ctrl
  import grid_pkg::*;
#(
  parameter int unsigned COLS          = GRID_COLS,
  parameter int unsigned ROWS          = GRID_ROWS,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_enter,
  input  logic [2:0] matrix_x,
  input  logic [1:0] matrix_y,
  input  logic       in_grid,
  input  logic       key_ready,
  output logic [2:0] cursor_x,
  output logic [1:0] cursor_y,
  output logic       highlight,
  output logic       key_valid,
  output logic [4:0] key_code
);

  localparam logic [2:0] X_LAST = 3'(COLS - 1);
  localparam logic [1:0] Y_LAST = 2'(ROWS - 1);

  // Bit order: {enter, right, left, down, up}
  logic [4:0] btn, btn_prev, press;
  dir_t       dir_q, press_dir, move_dir;
  logic       any_dir, start, step_c, busy_c, level, move_en;
  logic [2:0] x_next;
  logic [1:0] y_next;
  logic [4:0] cur_code;

  assign btn     = {btn_enter, btn_right, btn_left, btn_down, btn_up};
  assign press   = btn & ~btn_prev;
  assign any_dir = |press[3:0];
  assign start   = any_dir & ~busy_c;
  assign move_en = start | step_c;
  assign move_dir = start ? press_dir : dir_q;
  assign cur_code = 5'(cursor_y) * 5'(COLS) + 5'(cursor_x);

  // Resolve simultaneous direction presses: up > down > left > right.
  always_comb begin
    press_dir = DIR_RIGHT;
    if (press[0])      press_dir = DIR_UP;
    else if (press[1]) press_dir = DIR_DOWN;
    else if (press[2]) press_dir = DIR_LEFT;
  end

  // Level of the button that owns the current hold/repeat sequence.
  always_comb begin
    level = 1'b0;
    case (dir_q)
      DIR_UP:    level = btn_up;
      DIR_DOWN:  level = btn_down;
      DIR_LEFT:  level = btn_left;
      DIR_RIGHT: level = btn_right;
      default:   level = 1'b0;
    endcase
  end

  // Wrapping cursor arithmetic, each axis independent.
  always_comb begin
    x_next = cursor_x;
    y_next = cursor_y;
    if (move_en) begin
      case (move_dir)
        DIR_UP:    y_next = (cursor_y == 2'd0)   ? Y_LAST : cursor_y - 2'd1;
        DIR_DOWN:  y_next = (cursor_y == Y_LAST) ? 2'd0   : cursor_y + 2'd1;
        DIR_LEFT:  x_next = (cursor_x == 3'd0)   ? X_LAST : cursor_x - 3'd1;
        DIR_RIGHT: x_next = (cursor_x == X_LAST) ? 3'd0   : cursor_x + 3'd1;
        default: ;
      endcase
    end
  end

  key_repeat_timer #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .level  (level),
    .step_c (step_c),
    .busy_c (busy_c)
  );

  // Button history; ones at reset so a held button needs a release first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_prev <= '1;
    else     btn_prev <= btn;
  end

  // Cursor position and latched direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_x <= '0;
      cursor_y <= '0;
      dir_q    <= DIR_UP;
    end else begin
      cursor_x <= x_next;
      cursor_y <= y_next;
      if (start) dir_q <= press_dir;
    end
  end

  // Enter handshake: capture pre-move cursor code, hold until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
    end else if (!key_valid) begin
      if (press[4]) begin
        key_valid <= 1'b1;
        key_code  <= cur_code;
      end
    end else if (key_ready) begin
      key_valid <= 1'b0;
    end
  end

  // Registered highlight of the selected cell for the renderer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) highlight <= 1'b0;
    else     highlight <= in_grid && (matrix_x == cursor_x) && (matrix_y == cursor_y);
  end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Directed self-checking bench for grid_cursor_ctrl (HOLD_CYCLES=4, REPEAT_CYCLES=2).
module tb_grid_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_enter;
  logic [2:0] matrix_x;
  logic [1:0] matrix_y;
  logic       in_grid, key_ready;
  logic [2:0] cursor_x;
  logic [1:0] cursor_y;
  logic       highlight, key_valid;
  logic [4:0] key_code;

  int vectors = 0;
  int miscompares = 0;

  grid_cursor_ctrl #(
    .COLS          (6),
    .ROWS          (4),
    .HOLD_CYCLES   (4),
    .REPEAT_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_enter (btn_enter),
    .matrix_x  (matrix_x),
    .matrix_y  (matrix_y),
    .in_grid   (in_grid),
    .key_ready (key_ready),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .highlight (highlight),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  always #5 clk = ~clk;

  // Advance one active edge; outputs are then read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle press of a button (0 up, 1 down, 2 left, 3 right, 4 enter) then release.
  task automatic pulse(input int b);
    case (b)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      2: btn_left = 1'b1;
      3: btn_right = 1'b1;
      default: btn_enter = 1'b1;
    endcase
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_enter = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_enter = 1'b0;
    matrix_x = 3'd0; matrix_y = 2'd0; in_grid = 1'b1; key_ready = 1'b0;
    tick(); tick();
    vectors++;
    if (cursor_x !== 3'd0 || cursor_y !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_cursor: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y);
    end
    vectors++;
    if (key_valid !== 1'b0 || key_code !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_key: got valid=%0d code=%0d expected valid=0 code=0", key_valid, key_code);
    end
    vectors++;
    if (highlight !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_highlight: got %0d expected 0", highlight);
    end
    rst = 1'b0;
    in_grid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_right_wrap();
    logic [2:0] exp_x;
    for (int i = 0; i < 6; i++) begin
      exp_x = 3'((i + 1) % 6);
      btn_right = 1'b1;
      tick();
      vectors++;
      if (cursor_x !== exp_x || cursor_y !== 2'd0) begin
        miscompares++;
        $display("FAIL right_step%0d: got (%0d,%0d) expected (%0d,0)", i, cursor_x, cursor_y, exp_x);
      end
      btn_right = 1'b0;
      tick();
    end
  endtask

  task automatic test_left_hold();
    logic [2:0] exp_x [10];
    exp_x = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2};
    btn_left = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      vectors++;
      if (cursor_x !== exp_x[j]) begin
        miscompares++;
        $display("FAIL left_hold_cyc%0d: got x=%0d expected %0d", j, cursor_x, exp_x[j]);
      end
    end
    btn_left = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (cursor_x !== 3'd2 || cursor_y !== 2'd0) begin
      miscompares++;
      $display("FAIL left_release: got (%0d,%0d) expected (2,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_simultaneous();
    btn_up = 1'b1;
    btn_right = 1'b1;
    tick();
    vectors++;
    if (cursor_x !== 3'd2 || cursor_y !== 2'd3) begin
      miscompares++;
      $display("FAIL up_right_priority: got (%0d,%0d) expected (2,3)", cursor_x, cursor_y);
    end
    tick();
    btn_up = 1'b0;
    btn_right = 1'b0;
    tick(); tick();
    vectors++;
    if (cursor_x !== 3'd2 || cursor_y !== 2'd3) begin
      miscompares++;
      $display("FAIL up_right_release: got (%0d,%0d) expected (2,3)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_enter();
    // (2,3) -> down wraps to (2,0) -> (2,1)
    pulse(1);
    pulse(1);
    vectors++;
    if (cursor_x !== 3'd2 || cursor_y !== 2'd1) begin
      miscompares++;
      $display("FAIL enter_setup: got (%0d,%0d) expected (2,1)", cursor_x, cursor_y);
    end
    btn_enter = 1'b1;
    tick();
    vectors++;
    if (key_valid !== 1'b1 || key_code !== 5'd8) begin
      miscompares++;
      $display("FAIL enter_capture: got valid=%0d code=%0d expected valid=1 code=8", key_valid, key_code);
    end
    btn_enter = 1'b0;
    tick();
    pulse(3);
    pulse(4);
    vectors++;
    if (cursor_x !== 3'd3 || key_valid !== 1'b1 || key_code !== 5'd8) begin
      miscompares++;
      $display("FAIL enter_pending_hold: got x=%0d valid=%0d code=%0d expected x=3 valid=1 code=8", cursor_x, key_valid, key_code);
    end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    vectors++;
    if (key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL enter_accept: got valid=%0d expected 0", key_valid);
    end
    // New key at (3,1) = 9, then a press coinciding with acceptance is dropped.
    pulse(4);
    vectors++;
    if (key_valid !== 1'b1 || key_code !== 5'd9) begin
      miscompares++;
      $display("FAIL enter_second: got valid=%0d code=%0d expected valid=1 code=9", key_valid, key_code);
    end
    key_ready = 1'b1;
    btn_enter = 1'b1;
    tick();
    key_ready = 1'b0;
    tick();
    vectors++;
    if (key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL enter_drop_on_accept: got valid=%0d expected 0", key_valid);
    end
    btn_enter = 1'b0;
    tick();
  endtask

  task automatic test_highlight();
    int hits = 0;
    logic exp_h;
    pulse(1);
    vectors++;
    if (cursor_x !== 3'd3 || cursor_y !== 2'd2) begin
      miscompares++;
      $display("FAIL hl_setup: got (%0d,%0d) expected (3,2)", cursor_x, cursor_y);
    end
    in_grid = 1'b1;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 6; x++) begin
        matrix_x = 3'(x);
        matrix_y = 2'(y);
        exp_h = (x == 3 && y == 2);
        tick();
        if (highlight === 1'b1) hits++;
        vectors++;
        if (highlight !== exp_h) begin
          miscompares++;
          $display("FAIL hl_cell_%0d_%0d: got %0d expected %0d", x, y, highlight, exp_h);
        end
      end
    end
    vectors++;
    if (hits != 1) begin
      miscompares++;
      $display("FAIL hl_count: got %0d expected 1", hits);
    end
    matrix_x = 3'd3;
    matrix_y = 2'd2;
    in_grid = 1'b0;
    tick();
    vectors++;
    if (highlight !== 1'b0) begin
      miscompares++;
      $display("FAIL hl_outside: got %0d expected 0", highlight);
    end
  endtask

  task automatic test_reset_mid_hold();
    pulse(4);
    btn_down = 1'b1;
    tick();
    vectors++;
    if (cursor_y !== 2'd3 || key_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: got y=%0d valid=%0d expected y=3 valid=1", cursor_y, key_valid);
    end
    rst = 1'b1;
    #2;
    vectors++;
    if (cursor_x !== 3'd0 || cursor_y !== 2'd0 || key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: got (%0d,%0d) valid=%0d expected (0,0) valid=0", cursor_x, cursor_y, key_valid);
    end
    tick();
    rst = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    vectors++;
    if (cursor_x !== 3'd0 || cursor_y !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_held_btn: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y);
    end
    btn_down = 1'b0;
    tick();
    pulse(1);
    vectors++;
    if (cursor_x !== 3'd0 || cursor_y !== 2'd1) begin
      miscompares++;
      $display("FAIL rst_repress: got (%0d,%0d) expected (0,1)", cursor_x, cursor_y);
    end
  endtask

  initial begin
    test_reset();
    test_right_wrap();
    test_left_hold();
    test_simultaneous();
    test_enter();
    test_highlight();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
